// File: rtl/cmp_slice_accumulator.sv
// cmp_slice_accumulator: folds MSB-first 2-bit slice compare results
// (g/l/e) into a registered word-level gt/lt/eq result.
// The first non-equal slice decides the word; later slices are only counted.
// Optional build macro CMP_ONEHOT_CHECK_EN: flags non-one-hot slices on a
// sticky err output and decodes them as equal. Without the macro, err is 0
// and slices decode with priority g > l > e.
module cmp_slice_accumulator #(
    parameter int NSLICES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       slice_valid,
    input  logic       g,
    input  logic       l,
    input  logic       e,
    output logic       busy,
    output logic       done,
    output logic       gt,
    output logic       lt,
    output logic       eq,
    output logic [3:0] slice_cnt,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // slice_cnt is 4 bits; it saturates at 15 so NSLICES=16 still terminates
    localparam logic [3:0] LAST_CNT = 4'(NSLICES - 1);
    localparam logic [3:0] MAX_CNT  = 4'hF;

    state_t     r_state;
    state_t     w_next;
    logic       r_decided;
    logic       r_gt;
    logic       r_lt;
    logic       r_eq;
    logic [3:0] r_cnt;

    logic w_accept;
    logic w_launch;
    logic w_last;
    logic w_g;
    logic w_l;

    assign w_accept = (r_state == S_RUN) && slice_valid;
    // start is only honoured outside RUN; it also swallows any same-cycle slice
    assign w_launch = (r_state != S_RUN) && start;
    assign w_last   = w_accept && (r_cnt == LAST_CNT);

`ifdef CMP_ONEHOT_CHECK_EN
    logic w_onehot;
    logic r_err;

    // exactly one of three: odd parity rules out 0 and 2, the AND rules out 3
    assign w_onehot = (g ^ l ^ e) & ~(g & l & e);
    // a malformed slice decodes as equal so it can never decide the word
    assign w_g      = g & w_onehot;
    assign w_l      = l & w_onehot;
    assign err      = r_err;

    // sticky protocol error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_onehot) begin
            r_err <= 1'b1;
        end
    end
`else
    // e carries no information once g and l are known; kept for port parity
    logic w_unused_e;
    assign w_unused_e = e;
    assign w_g        = g;
    assign w_l        = l & ~g;
    assign err        = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state: DONE lasts one cycle unless a new word starts right away
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // word result and slice count; held outside RUN until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 4'd0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_eq      <= 1'b0;
        end else if (w_launch) begin
            r_cnt     <= 4'd0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_eq      <= 1'b1;
        end else if (w_accept) begin
            if (r_cnt != MAX_CNT) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (!r_decided) begin
                if (w_g) begin
                    r_gt      <= 1'b1;
                    r_eq      <= 1'b0;
                    r_decided <= 1'b1;
                end else if (w_l) begin
                    r_lt      <= 1'b1;
                    r_eq      <= 1'b0;
                    r_decided <= 1'b1;
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign gt        = r_gt;
    assign lt        = r_lt;
    assign eq        = r_eq;
    assign slice_cnt = r_cnt;

endmodule

// File: tb/tb_cmp_slice_accumulator.sv
// Bench for cmp_slice_accumulator (NSLICES=4). A word-level model keeps the
// list of slices accepted in the current word and derives the result from the
// first non-equal slice; outputs are compared against it every cycle, and
// literal expectations at key points pin the model.
// Build with +define+CMP_ONEHOT_CHECK_EN to exercise the one-hot check build.
module tb_cmp_slice_accumulator;

    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       slice_valid;
    logic       g;
    logic       l;
    logic       e;
    logic       busy;
    logic       done;
    logic       gt;
    logic       lt;
    logic       eq;
    logic [3:0] slice_cnt;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    // model: 0 = idle, 1 = run, 2 = done; slice codes 0 = equal, 1 = gt, 2 = lt
    int m_mode = 0;
    int m_n    = 0;
    int m_word = 0;
    int m_err  = 0;
    int m_sl[16];

    cmp_slice_accumulator #(.NSLICES(NS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .slice_valid (slice_valid),
        .g           (g),
        .l           (l),
        .e           (e),
        .busy        (busy),
        .done        (done),
        .gt          (gt),
        .lt          (lt),
        .eq          (eq),
        .slice_cnt   (slice_cnt),
        .err         (err)
    );

    always #5 clk = ~clk;

    function void chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    // behavioural model of the word protocol
    always @(posedge clk or negedge rst_n) begin
        int code;
        int ones;
        if (!rst_n) begin
            m_mode = 0;
            m_n    = 0;
            m_word = 0;
            m_err  = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1;
                m_n    = 0;
                m_word = 1;
            end else begin
                m_mode = 0;
            end
        end else if (slice_valid) begin
            ones = int'(g) + int'(l) + int'(e);
`ifdef CMP_ONEHOT_CHECK_EN
            if (ones != 1) begin
                code  = 0;
                m_err = 1;
            end else begin
                code = g ? 1 : (l ? 2 : 0);
            end
`else
            code = g ? 1 : (l ? 2 : 0);
            if (ones > 3) m_err = 1;
`endif
            m_sl[m_n] = code;
            m_n++;
            if (m_n == NS) m_mode = 2;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        int mg;
        int ml;
        int me;
        mg = 0;
        ml = 0;
        me = 0;
        if (m_word != 0) begin
            me = 1;
            for (int i = 0; i < m_n; i++) begin
                if (m_sl[i] != 0) begin
                    mg = (m_sl[i] == 1) ? 1 : 0;
                    ml = (m_sl[i] == 2) ? 1 : 0;
                    me = 0;
                    break;
                end
            end
        end
        chk("busy", int'(busy), (m_mode == 1) ? 1 : 0);
        chk("done", int'(done), (m_mode == 2) ? 1 : 0);
        chk("gt", int'(gt), mg);
        chk("lt", int'(lt), ml);
        chk("eq", int'(eq), me);
        chk("slice_cnt", int'(slice_cnt), (m_n > 15) ? 15 : m_n);
        chk("err", int'(err), m_err);
    end

    task automatic cyc(input logic s, input logic v, input logic gg, input logic ll, input logic ee);
        @(negedge clk);
        #1;
        start       = s;
        slice_valid = v;
        g           = gg;
        l           = ll;
        e           = ee;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_gt"}, int'(gt), 0);
        chk({tag, "_lt"}, int'(lt), 0);
        chk({tag, "_eq"}, int'(eq), 0);
        chk({tag, "_cnt"}, int'(slice_cnt), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        slice_valid = 1'b0;
        g           = 1'b0;
        l           = 1'b0;
        e           = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("reset");

        // release and start on the very first edge
        rst_n = 1'b1;
        start = 1'b1;
        settle();
        chk("first_start_busy", int'(busy), 1);
        chk("first_start_eq", int'(eq), 1);

        // x=00_11_10_01 vs y=00_11_01_11: e, e, g, l
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 1, 0, 0);
        settle();
        chk("A3_gt", int'(gt), 1);
        chk("A3_done", int'(done), 0);
        chk("A3_cnt", int'(slice_cnt), 3);
        cyc(0, 1, 0, 1, 0);
        settle();
        chk("A_done", int'(done), 1);
        chk("A_gt", int'(gt), 1);
        chk("A_lt", int'(lt), 0);
        chk("A_eq", int'(eq), 0);
        chk("A_cnt", int'(slice_cnt), 4);
        cyc(0, 0, 0, 0, 0);
        // slice in IDLE must not disturb the held result
        cyc(0, 1, 0, 1, 0);
        settle();
        chk("idle_hold_gt", int'(gt), 1);
        chk("idle_hold_cnt", int'(slice_cnt), 4);

        // 8'hA5 vs 8'hA5 with a two-cycle gap after slice 2
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        settle();
        chk("B_gap_done", int'(done), 0);
        chk("B_gap_cnt", int'(slice_cnt), 2);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        settle();
        chk("B_done", int'(done), 1);
        chk("B_eq", int'(eq), 1);

        // start with a slice in the DONE cycle: slice discarded
        cyc(1, 1, 1, 0, 0);
        settle();
        chk("C_restart_busy", int'(busy), 1);
        chk("C_restart_cnt", int'(slice_cnt), 0);
        chk("C_restart_gt", int'(gt), 0);
        // l first, then g (start ignored in RUN), g, e
        cyc(0, 1, 0, 1, 0);
        cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 1);
        settle();
        chk("C_done", int'(done), 1);
        chk("C_lt", int'(lt), 1);
        chk("C_gt", int'(gt), 0);
        chk("C_cnt", int'(slice_cnt), 4);
        cyc(0, 0, 0, 0, 0);

        // reset mid-word
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 1);
        @(negedge clk);
        #1;
        start       = 1'b0;
        slice_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        settle();
        chk("D_nodone", int'(done), 0);
        chk("D_busy", int'(busy), 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        settle();
        chk("D_done", int'(done), 1);
        chk("D_eq", int'(eq), 1);
        cyc(0, 0, 0, 0, 0);

        // non-one-hot first slice g=l=1, then three equal slices
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        settle();
        chk("E_done", int'(done), 1);
`ifdef CMP_ONEHOT_CHECK_EN
        chk("E_err", int'(err), 1);
        chk("E_eq", int'(eq), 1);
        chk("E_gt", int'(gt), 0);
`else
        chk("E_err", int'(err), 0);
        chk("E_eq", int'(eq), 0);
        chk("E_gt", int'(gt), 1);
`endif

        // zero slice, e, l+e, g
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 1, 0, 0);
        settle();
        chk("F_done", int'(done), 1);
`ifdef CMP_ONEHOT_CHECK_EN
        chk("F_err_sticky", int'(err), 1);
        chk("F_gt", int'(gt), 1);
        chk("F_lt", int'(lt), 0);
`else
        chk("F_err", int'(err), 0);
        chk("F_gt", int'(gt), 0);
        chk("F_lt", int'(lt), 1);
`endif
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
